// File: rtl/mem_access_controller_if.sv
// +--------------------------------------------------------------------------+
// | mem_access_controller_if : client/arbiter and memory-port bundle         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mem_access_controller_if #(
  parameter int NUM_CLIENTS = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32
);
  logic [NUM_CLIENTS-1:0]            grants;
  logic                              hold;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cli_addr;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_wdata;
  logic [NUM_CLIENTS-1:0]            cli_we;
  logic [NUM_CLIENTS-1:0]            cli_done;
  logic [DATA_WIDTH-1:0]             cli_rdata;
  logic                              cli_err;
  logic                              mem_req;
  logic                              mem_we;
  logic [ADDR_WIDTH-1:0]             mem_addr;
  logic [DATA_WIDTH-1:0]             mem_wdata;
  logic                              mem_ack;
  logic [DATA_WIDTH-1:0]             mem_rdata;

  modport master (
    input  grants, cli_addr, cli_wdata, cli_we, mem_ack, mem_rdata,
    output hold, cli_done, cli_rdata, cli_err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output grants, cli_addr, cli_wdata, cli_we, mem_ack, mem_rdata,
    input  hold, cli_done, cli_rdata, cli_err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access_controller.sv
// +--------------------------------------------------------------------------+
// | mem_access_controller : grant-driven single-beat memory access with      |
// | watchdog abort.  Rev 1.0                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_access_controller #(
  parameter int NUM_CLIENTS    = 8,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mem_access_controller_if.master bus
);

  localparam int c_idx_w = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last =
      c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [c_idx_w-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [c_cnt_w-1:0]      cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_CLIENTS-1:0]  done_q, done_d;
  logic                    hold_q, hold_d;
  logic                    req_q, req_d;
  logic [c_idx_w-1:0]      sel_idx;

  // Descending scan so the lowest set grant bit wins on a non-one-hot vector.
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (bus.grants[i]) sel_idx = c_idx_w'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    done_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (|bus.grants) begin
          idx_d   = sel_idx;
          addr_d  = bus.cli_addr[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = bus.cli_wdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
          we_d    = bus.cli_we[sel_idx];
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_ack) begin
          rdata_d = bus.mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          // Counter holds the number of unacknowledged REQ cycles already spent.
          if ((TIMEOUT_CYCLES != 0) && (cnt_q == c_cnt_last)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    hold_d = (state_d != S_IDLE);
    req_d  = (state_d == S_REQ);
    if (state_d == S_RESP) done_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      done_q  <= '0;
      hold_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      hold_q  <= hold_d;
      req_q   <= req_d;
    end
  end

  assign bus.hold      = hold_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cli_done  = done_q;
  assign bus.cli_rdata = rdata_q;
  assign bus.cli_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_controller.sv
// +--------------------------------------------------------------------------+
// | tb_mem_access_controller : directed + randomized bench with a            |
// | transaction-level reference model.  Rev 1.0                              |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_access_controller;

  localparam int NC  = 8;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_controller_if #(.NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  mem_access_controller #(
    .NUM_CLIENTS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Expected outputs for the current cycle.
  logic          e_hold, e_req, e_we, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [NC-1:0] e_done;

  // Transaction-level model state.
  bit m_busy, m_answered;
  int m_idx, m_waited;

  bit            arb_en, ack_now;
  logic [NC-1:0] reqs;
  int            ptr;

  function automatic int lowest(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [NC-1:0] rr_grant(input logic [NC-1:0] r, input int p);
    logic [NC-1:0] g;
    g = '0;
    for (int k = 0; k < NC; k++) begin
      if (r[(p + k) % NC]) begin
        g[(p + k) % NC] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    e_hold = 0; e_req = 0; e_we = 0; e_err = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_done = '0;
    m_busy = 0; m_answered = 0; m_idx = 0; m_waited = 0;
  endtask

  // Advance the model across the coming rising edge using the inputs now on the bus.
  task automatic model_advance();
    if (!m_busy) begin
      e_done = '0;
      if (bus_if.grants != '0) begin
        m_idx    = lowest(bus_if.grants);
        e_addr   = bus_if.cli_addr[m_idx*AW +: AW];
        e_wdata  = bus_if.cli_wdata[m_idx*DW +: DW];
        e_we     = bus_if.cli_we[m_idx];
        m_busy   = 1; m_waited = 0;
        e_req    = 1; e_hold = 1;
      end
    end else if (m_answered) begin
      m_busy = 0; m_answered = 0;
      e_done = '0; e_hold = 0;
    end else begin
      m_waited++;
      if (bus_if.mem_ack || m_waited == TMO) begin
        e_err      = !bus_if.mem_ack;
        e_rdata    = bus_if.mem_ack ? bus_if.mem_rdata : '0;
        m_answered = 1;
        e_req      = 0;
        e_done     = '0;
        e_done[m_idx] = 1'b1;
      end
    end
  endtask

  task automatic model_check();
    if (!rst_n) model_reset();
    n_tests++;
    if ({bus_if.hold, bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr, bus_if.mem_wdata,
         bus_if.cli_done, bus_if.cli_rdata, bus_if.cli_err} !==
        {e_hold, e_req, e_we, e_addr, e_wdata, e_done, e_rdata, e_err}) begin
      n_fail++;
      $display("FAIL cycle_cmp at %0t: got hold=%b req=%b we=%b addr=%h wdata=%h done=%b rdata=%h err=%b; expected hold=%b req=%b we=%b addr=%h wdata=%h done=%b rdata=%h err=%b",
               $time, bus_if.hold, bus_if.mem_req, bus_if.mem_we, bus_if.mem_addr,
               bus_if.mem_wdata, bus_if.cli_done, bus_if.cli_rdata, bus_if.cli_err,
               e_hold, e_req, e_we, e_addr, e_wdata, e_done, e_rdata, e_err);
    end
    if (rst_n) model_advance();
  endtask

  // One clock: compare on the falling edge, then drive new inputs 2ns after the rising edge.
  task automatic tick();
    int  g;
    bit  adv;
    @(negedge clk);
    model_check();
    g   = lowest(bus_if.grants);
    adv = arb_en && (rst_n === 1'b1) && (g >= 0) && !bus_if.hold;
    @(posedge clk);
    if (adv) ptr = (g + 1) % NC;
    #2;
    if (arb_en) begin
      for (int i = 0; i < NC; i++) if (bus_if.cli_done[i]) reqs[i] = 1'b0;
      bus_if.grants = rr_grant(reqs, ptr);
    end
    if (ack_now) bus_if.mem_ack = bus_if.mem_req;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int order[NC];
    int n_served;

    rst_n = 1'b0;
    arb_en = 0; ack_now = 0; reqs = '0; ptr = 0;
    bus_if.grants = '0; bus_if.cli_addr = '0; bus_if.cli_wdata = '0; bus_if.cli_we = '0;
    bus_if.mem_ack = 1'b0; bus_if.mem_rdata = '0;
    model_reset();
    repeat (3) tick();
    check("reset_outputs", 64'({bus_if.hold, bus_if.mem_req, bus_if.mem_we, bus_if.cli_err,
                                bus_if.cli_done, bus_if.mem_addr}), 64'(0));
    check("reset_data", 64'({bus_if.mem_wdata, bus_if.cli_rdata}), 64'(0));
    rst_n = 1'b1;
    tick();

    // Read by client 2, ack two cycles after mem_req rises.
    bus_if.cli_addr[2*AW +: AW] = 16'h0040;
    bus_if.cli_we[2] = 1'b0;
    bus_if.mem_rdata = 32'hDEADBEEF;
    bus_if.grants = 8'b0000_0100;
    tick();
    check("rd_req", 64'({bus_if.mem_req, bus_if.hold, bus_if.mem_we}), 64'(3'b110));
    check("rd_addr", 64'(bus_if.mem_addr), 64'h0040);
    tick(); tick();
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    check("rd_done", 64'(bus_if.cli_done), 64'(8'b0000_0100));
    check("rd_rdata", 64'(bus_if.cli_rdata), 64'hDEADBEEF);
    check("rd_err_hold", 64'({bus_if.cli_err, bus_if.hold}), 64'(2'b01));
    bus_if.grants = '0;
    tick();
    check("rd_idle", 64'({bus_if.hold, bus_if.cli_done}), 64'(0));

    // Write by client 7 with same-cycle ack.
    bus_if.cli_addr[7*AW +: AW] = 16'h1234;
    bus_if.cli_wdata[7*DW +: DW] = 32'hA5A5A5A5;
    bus_if.cli_we[7] = 1'b1;
    bus_if.grants = 8'b1000_0000;
    tick();
    check("wr_we_addr", 64'({bus_if.mem_we, bus_if.mem_addr}), 64'({1'b1, 16'h1234}));
    check("wr_wdata", 64'(bus_if.mem_wdata), 64'hA5A5A5A5);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    check("wr_done", 64'(bus_if.cli_done), 64'(8'b1000_0000));
    bus_if.grants = '0;
    tick();

    // Grant change while busy must not disturb the client-2 transaction.
    bus_if.cli_addr[0] = 1'b0;
    bus_if.cli_addr[0*AW +: AW] = 16'h0999;
    bus_if.cli_we[0] = 1'b0;
    bus_if.grants = 8'b0000_0100;
    tick();
    bus_if.grants = 8'b0000_0001;
    tick(); tick();
    check("busy_addr", 64'(bus_if.mem_addr), 64'h0040);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    check("busy_done", 64'(bus_if.cli_done), 64'(8'b0000_0100));
    tick(); tick();
    check("next_addr", 64'(bus_if.mem_addr), 64'h0999);
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    check("next_done", 64'(bus_if.cli_done), 64'(8'b0000_0001));
    bus_if.grants = '0;
    tick();

    // Watchdog: no ack at all.
    bus_if.cli_addr[4*AW +: AW] = 16'h0444;
    bus_if.grants = 8'b0001_0000;
    tick();
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (bus_if.mem_req) cnt++;
      if (bus_if.cli_done != '0) break;
      tick();
    end
    check("tmo_req_cycles", 64'(cnt), 64'(TMO));
    check("tmo_done", 64'(bus_if.cli_done), 64'(8'b0001_0000));
    check("tmo_err_rdata", 64'({bus_if.cli_err, bus_if.cli_rdata}), 64'({1'b1, 32'h0}));
    bus_if.grants = '0;
    bus_if.mem_ack = 1'b1;
    bus_if.mem_rdata = 32'h12345678;
    tick(); tick();
    check("late_ack_ignored", 64'({bus_if.cli_done, bus_if.mem_req, bus_if.cli_rdata}), 64'(0));
    bus_if.mem_ack = 1'b0;
    tick();

    // Back-to-back with a round-robin arbiter, all eight clients requesting.
    for (int i = 0; i < NC; i++) begin
      bus_if.cli_addr[i*AW +: AW] = AW'(16'h0100 + i);
      bus_if.cli_we[i] = 1'b0;
    end
    bus_if.mem_rdata = 32'hC0DE0000;
    reqs = '1; ptr = 0; arb_en = 1; ack_now = 1;
    bus_if.grants = rr_grant(reqs, ptr);
    n_served = 0;
    for (int k = 0; k < 80 && n_served < NC; k++) begin
      tick();
      if (bus_if.cli_done != '0) begin
        order[n_served] = lowest(bus_if.cli_done);
        n_served++;
      end
    end
    check("rr_served", 64'(n_served), 64'(NC));
    for (int k = 0; k < NC; k++) check("rr_order", 64'(k < n_served ? order[k] : -1), 64'(k));
    arb_en = 0; ack_now = 0; bus_if.grants = '0; bus_if.mem_ack = 1'b0;
    tick(); tick();

    // Asynchronous reset in the middle of REQ.
    bus_if.cli_addr[1*AW +: AW] = 16'h0111;
    bus_if.grants = 8'b0000_0010;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("arst_req_hold", 64'({bus_if.mem_req, bus_if.hold}), 64'(0));
    bus_if.grants = '0;
    tick(); tick();
    rst_n = 1'b1;
    bus_if.grants = 8'b0000_0010;
    bus_if.mem_rdata = 32'h0BADF00D;
    tick();
    bus_if.mem_ack = 1'b1;
    tick();
    bus_if.mem_ack = 1'b0;
    check("arst_fresh_done", 64'({bus_if.cli_done, bus_if.cli_rdata}), 64'({8'b0000_0010, 32'h0BADF00D}));
    bus_if.grants = '0;
    tick();

    // Randomized traffic, including non-one-hot grants and stray acks.
    for (int k = 0; k < 1500; k++) begin
      bus_if.grants = ($urandom_range(0, 1) != 0) ? NC'($urandom) : '0;
      for (int i = 0; i < NC; i++) begin
        bus_if.cli_addr[i*AW +: AW]  = AW'($urandom);
        bus_if.cli_wdata[i*DW +: DW] = DW'($urandom);
      end
      bus_if.cli_we    = NC'($urandom);
      bus_if.mem_ack   = ($urandom_range(0, 4) < 2);
      bus_if.mem_rdata = DW'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_controller.md
# mem_access_controller

Downstream consumer of the round-robin arbitration unit. It accepts the one-hot grant, captures the winning client's command, and runs one single-beat transaction on the shared memory port. It asserts `hold` toward the arbiter for the life of the transaction and returns read data with a one-cycle done pulse to the owning client. A watchdog aborts any transaction the memory never acknowledges.

## Interface
Parameters:
- NUM_CLIENTS, 8, number of arbitrated clients; must match the arbiter.
- ADDR_WIDTH, 16, memory address width.
- DATA_WIDTH, 32, memory data width.
- TIMEOUT_CYCLES, 64, maximum REQ-state cycles without `mem_ack` before abort; 0 disables the watchdog.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- grants  in  NUM_CLIENTS  one-hot grant from the arbiter; all-zero means no request.
- hold  out  1  freezes the arbiter's round-robin pointer.
- cli_addr  in  NUM_CLIENTS*ADDR_WIDTH  per-client address; client i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- cli_wdata  in  NUM_CLIENTS*DATA_WIDTH  per-client write data, packed the same way.
- cli_we  in  NUM_CLIENTS  per-client write enable; 1 = write, 0 = read.
- cli_done  out  NUM_CLIENTS  one-hot, one-cycle completion pulse to the owning client.
- cli_rdata  out  DATA_WIDTH  read data; shared by all clients; valid only while `cli_done` is nonzero.
- cli_err  out  1  high together with `cli_done` when the transaction timed out.
- mem_req  out  1  memory request, level.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_ack  in  1  memory acknowledge; `mem_rdata` is valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  memory read data.

## Operation
- The FSM has three states: IDLE, REQ, RESP.
- **IDLE:**
  - If `grants` != 0 at the clock edge, capture the following: the client index (lowest set bit if `grants` is not one-hot), that client's `cli_addr`, `cli_wdata` and `cli_we`.
  - Clear the watchdog counter and go to REQ.
  - Otherwise stay in IDLE.
- **REQ:**
  - `mem_req` = 1. `mem_we`, `mem_addr` and `mem_wdata` are driven from the captured registers and stay stable.
  - On `mem_ack` = 1: register `mem_rdata` into `cli_rdata`, clear the error flag, go to RESP.
  - Otherwise increment the counter. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1, set the error flag, force `cli_rdata` to 0, and go to RESP.
  - The counter width is $clog2(TIMEOUT_CYCLES+1) and the counter saturates; it never wraps.
- **RESP:**
  - `cli_done[idx]` = 1. `cli_err` = error flag.
  - Go to IDLE unconditionally.
- `hold` = (state != IDLE). It is a registered decode and is glitch-free.
- `mem_ack` is ignored outside REQ. A write returns `cli_rdata` = `mem_rdata` as sampled; clients ignore it.
- Client contract: keep `requests[i]` high and the command stable until `cli_done[i]`. Drop the request in the following cycle unless a new transaction is wanted.
- Grants arriving in REQ or RESP are ignored. Only grants sampled in IDLE start a transaction.
- Reset values: state IDLE; `hold`, `mem_req`, `mem_we`, `cli_err` = 0; `cli_done`, `mem_addr`, `mem_wdata`, `cli_rdata` = all zeros; counter = 0.
- Reset asserted mid-transaction: return to IDLE immediately (asynchronous), drop `mem_req` and `hold`, emit no `cli_done` pulse.

## Timing
- Edge C (IDLE with grant) → `mem_req` high from C+1.
- `mem_ack` in cycle C+1 → `cli_done` in C+2 → IDLE in C+3. The minimum transaction is 3 cycles and the minimum issue interval is 3 cycles.
- `cli_rdata` and `cli_err` are valid exactly in the `cli_done` cycle and hold their value until the next RESP.
- Timeout: with no ack, `mem_req` is high for exactly TIMEOUT_CYCLES cycles, then `cli_done` + `cli_err` follow in the next cycle.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset → all outputs 0. Grant 8'b0000_0100, read, addr 0x0040, ack 2 cycles after `mem_req` → `mem_addr` = 0x0040, `mem_we` = 0, `cli_done` = 8'b0000_0100 with `cli_rdata` = `mem_rdata` (0xDEADBEEF), `cli_err` = 0, `hold` high from C+1 through the RESP cycle.
- Write from client 7, addr 0x1234, data 0xA5A5A5A5, same-cycle ack → `mem_we` = 1, `mem_wdata` = 0xA5A5A5A5, `cli_done` = 8'b1000_0000 exactly 2 cycles after capture.
- Grant changes to 8'b0000_0001 while in REQ for client 2 → still client 2's address on `mem_addr`; `cli_done` = 8'b0000_0100; client 0 is served only after return to IDLE.
- No ack, TIMEOUT_CYCLES = 4 → `mem_req` high for exactly 4 cycles, then `cli_done` one-hot with `cli_err` = 1 and `cli_rdata` = 0; a late `mem_ack` after that is ignored.
- Back-to-back with the arbiter: all 8 requests held, 8 transactions → `cli_done` follows round-robin order 0..7, `hold` never drops mid-transaction, no client served twice.
- `rst_n` low while in REQ → `mem_req` and `hold` fall without a clock edge, no `cli_done`; after release, a fresh grant completes normally.
